// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_STEP       = 4;
  localparam int unsigned INSTR_W_DEF   = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_counter.sv
// 32-bit wrapping event counter with synchronous reset and increment enable.
module fetch_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, sync-read imem control, stall and redirect handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter int unsigned INSTR_W   = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [31:0]        R15
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_q, pc_nxt;
  logic [31:0]  ipc_q, ipc_nxt;
  logic [1:0]   unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
      pc_q  <= RESET_VEC;
      ipc_q <= RESET_VEC;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ipc_q <= ipc_nxt;
    end
  end

  // A stall only holds a full slot; an empty slot is always refilled.
  always_comb begin
    imem_en   = !redirect && (!stall || state == S_EMPTY);
    state_nxt = state;
    pc_nxt    = pc_q;
    ipc_nxt   = ipc_q;
    if (redirect) begin
      state_nxt = S_EMPTY;
      pc_nxt    = {redirect_pc[31:2], 2'b00};
    end else if (imem_en) begin
      state_nxt = S_FULL;
      ipc_nxt   = pc_q;
      pc_nxt    = pc_q + 32'(PC_STEP);
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = imem_rdata;
  assign instr_valid = (state == S_FULL);
  assign R15         = ipc_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (instr_valid && !stall),
    .count (fetch_count)
  );

  fetch_perf_counter u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (!instr_valid),
    .count (bubble_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle-level expectations plus a fetch scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, R15;
  logic        imem_en, instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count;
  logic [31:0] m_fetch, m_bubble;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;

  fetch_t      sb[$];
  logic [31:0] m_pc, m_ipc;
  logic        m_valid;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_VEC(RV), .INSTR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .R15         (R15)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  // Synchronous-read memory: word at A holds A ^ PAT, output holds when not enabled.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ PAT;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered and left at a negedge; holds rst for n rising edges.
  task automatic do_reset(input int unsigned n);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (n) @(negedge clk);
    m_pc = RV; m_ipc = RV; m_valid = 1'b0;
    sb.delete();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_R15", R15, RV);
    check("rst_addr", imem_addr, RV);
`ifdef FETCH_PERF_CNT_EN
    m_fetch = '0; m_bubble = '0;
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_bubble_count", bubble_count, 32'd0);
`endif
    rst = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check before the rising edge, update the model.
  task automatic cycle(input logic s, input logic r, input logic [31:0] rp);
    logic   exp_en;
    fetch_t e;
    stall = s; redirect = r; redirect_pc = rp;
    #1;
    exp_en = !r && (!s || !m_valid);
    check("imem_en", 32'(imem_en), 32'(exp_en));
    if (exp_en) check("imem_addr", imem_addr, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("R15", R15, m_ipc);
    if (m_valid) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb[0];
        check("instr", instr, e.data);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, m_fetch);
    check("bubble_count", bubble_count, m_bubble);
    if (m_valid && !s) m_fetch = m_fetch + 32'd1;
    if (!m_valid) m_bubble = m_bubble + 32'd1;
`endif
    if (r) begin
      if (m_valid && sb.size() > 0) sb.delete(0);
      m_pc    = {rp[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (exp_en) begin
      if (m_valid && sb.size() > 0) sb.delete(0);
      e.addr = m_pc;
      e.data = m_pc ^ PAT;
      sb.push_back(e);
      m_ipc   = m_pc;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    do_reset(2);

    // Sequential fetch, then a 3-cycle stall while R15 = 8.
    repeat (3) cycle(1'b0, 1'b0, '0);
    repeat (3) cycle(1'b1, 1'b0, '0);
    check("stall_R15_held", R15, 32'd8);
    check("stall_instr_held", instr, 32'd8 ^ PAT);
    repeat (2) cycle(1'b0, 1'b0, '0);

    // Redirect at R15 = 16 to an unaligned target.
    check("pre_redir_R15", R15, 32'd16);
    cycle(1'b0, 1'b1, 32'h0000_0103);
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_bubble", 32'(instr_valid), 32'd0);
    cycle(1'b0, 1'b0, '0);
    check("redir_R15", R15, 32'h0000_0100);
    check("redir_valid", 32'(instr_valid), 32'd1);
    cycle(1'b0, 1'b0, '0);

    // Redirect together with stall drops the held instruction.
    cycle(1'b1, 1'b1, 32'h0000_0040);
    check("rs_addr", imem_addr, 32'h0000_0040);
    repeat (3) cycle(1'b0, 1'b0, '0);

    // PC wrap-around.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0);
    check("wrap_R15_top", R15, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0);
    check("wrap_R15_zero", R15, 32'h0000_0000);
    cycle(1'b0, 1'b0, '0);

    // Random mix of stalls and redirects.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), $urandom);
    end

    // Ten cycles with one redirect, then reset mid-stream.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'(i == 5), 32'h0000_0200);
    end
    do_reset(1);
    repeat (3) cycle(1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
